phys_reg_freelist: RTL and testbench
====================================

// Module: phys_reg_freelist
// PURPOSE
//  Tracks which physical registers are unallocated and hands them out to the
//  rename stage of the frontend. Up to ALLOC_WIDTH registers are granted per
//  cycle, all-or-nothing. Registers retired through the completion free ports
//  (cmplt_free_regs) are returned, up to FREE_WIDTH per cycle.
//  Physical registers 0 and 1 are reserved constants; they are never allocated
//  or tracked.
// PARAMETERS
//  PHYS_REGS    64  total physical registers, including reserved 0 and 1
//  PR_ADDR_W     6  physical register address width, = $clog2(PHYS_REGS)
//  ALLOC_WIDTH   4  maximum allocations per cycle
//  FREE_WIDTH    6  free ports per cycle
//  ARCH_INIT     8  registers 2..ARCH_INIT+1 are busy at reset (initial arch map)
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous, active-high reset
//  alloc_count  in   $clog2(ALLOC_WIDTH+1) registers requested this cycle
//  alloc_valid  in   1                    request present
//  alloc_ready  out  1                    enough free registers for the request
//  alloc_regs   out  ALLOC_WIDTH*PR_ADDR_W granted registers; slot i at [i*PR_ADDR_W +: PR_ADDR_W]
//  free_regs    in   FREE_WIDTH*PR_ADDR_W registers to release; value 0 or 1 = slot unused
//  free_count   out  $clog2(PHYS_REGS+1)  registered count of free registers
//  empty        out  1                    free_count == 0
//  double_free  out  1                    sticky error flag
// BEHAVIOUR
//  - State
//    - free_mask[PHYS_REGS-1:2]: 1 = free.
//    - free_count: kept in step with free_mask; no popcount on the critical path.
//  - Reset (rst=1 at posedge)
//    - Bits 2..ARCH_INIT+1 of free_mask cleared; all other bits set.
//    - free_count = PHYS_REGS-2-ARCH_INIT.
//    - double_free = 0.
//    - Reset wins over any alloc or free in the same cycle. No partial grant.
//  - alloc_regs (combinational from registered free_mask)
//    - Slots 0..ALLOC_WIDTH-1 carry the ALLOC_WIDTH lowest-index free registers,
//      in ascending order.
//    - Slot i is valid only when i < alloc_count.
//    - Unused slots, and slots beyond the number of free registers, drive 0.
//  - alloc_ready = (free_count >= alloc_count).
//    - Independent of alloc_valid and of this cycle's frees.
//  - Grant
//    - Fires on alloc_valid & alloc_ready & alloc_count != 0.
//    - Slots 0..alloc_count-1 are cleared from free_mask at the posedge.
//    - free_count decreases by alloc_count.
//    - alloc_count > ALLOC_WIDTH is illegal; the block treats it as not ready.
//  - Free
//    - Each slot with value >= 2 sets its bit at the posedge; free_count
//      increases by the number of bits newly set.
//    - Freed registers become allocatable the next cycle. No same-cycle bypass.
//    - Slot value 0 or 1: ignored.
//    - Value >= PHYS_REGS: ignored, and double_free is set.
//  - Double free
//    - Freeing a register already free, or naming the same register in two
//      slots of one cycle, sets double_free.
//    - The bit stays set and is counted once only.
//  - Simultaneous grant and free in one cycle:
//    - free_mask_next = (free_mask & ~grant_bits) | free_bits.
//    - free_count_next = free_count - alloc_count + newly_freed.
//    - A register being granted cannot legally be freed in the same cycle
//      (it is free). If one is, double_free is set and the register stays
//      allocated.
//  - Boundaries
//    - free_count == 0: empty = 1; alloc_ready = 1 only for alloc_count == 0.
//    - free_count never exceeds PHYS_REGS-2 and never underflows.
//  - Latency: 0 cycles request to grant; 1 cycle free to allocatable.
// TESTING
//  1. Reset, defaults -> free_count = 54; alloc_count=4 grants 10,11,12,13;
//     free_count = 50 next cycle.
//  2. Allocate 4 per cycle until free_count = 2; request 4 -> alloc_ready = 0,
//     mask unchanged. Request 2 -> grants 62,63; empty = 1.
//  3. Free 11 and alloc 1 in the same cycle -> grant is 14, not 11.
//     Next cycle alloc 1 -> 11. free_count net unchanged over the first cycle.
//  4. Free 5 when already free, or 20 in two slots at once -> double_free = 1
//     (sticky); free_count rises by 1 only.
//  5. free_regs slots = 0 and 1 -> no state change, no error.
//  6. Reset asserted during a grant cycle -> next-cycle state equals the
//     post-reset state (free_count = 54, double_free = 0).

Source files
------------

// File: rtl/phys_reg_freelist_if.sv
// Rename-stage allocation request, completion-side frees and freelist status,
// bundled between the frontend (master) and the physical register freelist (slave).
interface phys_reg_freelist_if #(
    parameter int PHYS_REGS   = 64,
    parameter int PR_ADDR_W   = $clog2(PHYS_REGS),
    parameter int ALLOC_WIDTH = 4,
    parameter int FREE_WIDTH  = 6
);
    logic [$clog2(ALLOC_WIDTH+1)-1:0] alloc_count;
    logic                             alloc_valid;
    logic                             alloc_ready;
    logic [ALLOC_WIDTH*PR_ADDR_W-1:0] alloc_regs;
    logic [FREE_WIDTH*PR_ADDR_W-1:0]  free_regs;
    logic [$clog2(PHYS_REGS+1)-1:0]   free_count;
    logic                             empty;
    logic                             double_free;

    modport master (
        output alloc_count, alloc_valid, free_regs,
        input  alloc_ready, alloc_regs, free_count, empty, double_free
    );

    modport slave (
        input  alloc_count, alloc_valid, free_regs,
        output alloc_ready, alloc_regs, free_count, empty, double_free
    );
endinterface

// File: rtl/phys_reg_freelist.sv
// Physical register freelist: hands the lowest-index free registers to rename
// (all-or-nothing, up to ALLOC_WIDTH per cycle) and takes back retired ones.
module phys_reg_freelist #(
    parameter int PHYS_REGS   = 64,
    parameter int PR_ADDR_W   = $clog2(PHYS_REGS),
    parameter int ALLOC_WIDTH = 4,
    parameter int FREE_WIDTH  = 6,
    parameter int ARCH_INIT   = 8
) (
    input  logic               clk,
    input  logic               rst,
    phys_reg_freelist_if.slave flBus_io
);
    localparam int CNT_W = $clog2(PHYS_REGS + 1);

    function automatic logic [PHYS_REGS-1:0] resetMask();
        logic [PHYS_REGS-1:0] m;
        m = '0;
        for (int r = ARCH_INIT + 2; r < PHYS_REGS; r++) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [PHYS_REGS-1:0] RESET_MASK = resetMask();

    // Bits 0 and 1 are the reserved constants and are held at zero forever.
    logic [PHYS_REGS-1:0]             freeMask_q, freeMask_d;
    logic [CNT_W-1:0]                 freeCount_q, freeCount_d;
    logic                             doubleFree_q, doubleFree_d;

    logic [PHYS_REGS-1:0]             pickRemain;
    logic [PR_ADDR_W-1:0]             pickReg [ALLOC_WIDTH];
    logic [ALLOC_WIDTH-1:0]           pickVld;

    logic [CNT_W-1:0]                 reqCount;
    logic                             allocLegal;
    logic                             allocReady;
    logic                             grantFire;
    logic [CNT_W-1:0]                 grantCount;
    logic [PHYS_REGS-1:0]             grantBits;
    logic [ALLOC_WIDTH*PR_ADDR_W-1:0] allocRegs;

    logic [PR_ADDR_W-1:0]             freeSlot [FREE_WIDTH];
    logic [PHYS_REGS-1:0]             freeBits;
    logic [CNT_W-1:0]                 newlyFreed;
    logic                             badFree;

    // Successive lowest-set-bit searches, each removing its pick from the candidates.
    always_comb begin
        pickRemain = freeMask_q;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            pickReg[i] = '0;
            pickVld[i] = 1'b0;
            for (int r = PHYS_REGS - 1; r >= 2; r--) begin
                if (pickRemain[r]) begin
                    pickReg[i] = PR_ADDR_W'(r);
                    pickVld[i] = 1'b1;
                end
            end
            if (pickVld[i]) begin
                pickRemain[pickReg[i]] = 1'b0;
            end
        end
    end

    assign reqCount   = CNT_W'(flBus_io.alloc_count);
    assign allocLegal = int'(flBus_io.alloc_count) <= ALLOC_WIDTH;
    assign allocReady = allocLegal && (freeCount_q >= reqCount);
    assign grantFire  = flBus_io.alloc_valid && allocReady && (reqCount != '0);
    assign grantCount = grantFire ? reqCount : '0;

    always_comb begin
        allocRegs = '0;
        grantBits = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if ((i < int'(flBus_io.alloc_count)) && pickVld[i]) begin
                allocRegs[i*PR_ADDR_W +: PR_ADDR_W] = pickReg[i];
                if (grantFire) begin
                    grantBits[pickReg[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < FREE_WIDTH; j++) begin
            freeSlot[j] = flBus_io.free_regs[j*PR_ADDR_W +: PR_ADDR_W];
        end
    end

    // A free of a register that is already free (including one being granted
    // right now) or repeated within the cycle is rejected and flagged.
    always_comb begin
        freeBits   = '0;
        newlyFreed = '0;
        badFree    = 1'b0;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (int'(freeSlot[j]) >= PHYS_REGS) begin
                badFree = 1'b1;
            end else if (int'(freeSlot[j]) >= 2) begin
                if (freeMask_q[freeSlot[j]] || freeBits[freeSlot[j]]) begin
                    badFree = 1'b1;
                end else begin
                    freeBits[freeSlot[j]] = 1'b1;
                    newlyFreed = newlyFreed + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        freeMask_d   = (freeMask_q & ~grantBits) | freeBits;
        freeCount_d  = freeCount_q - grantCount + newlyFreed;
        doubleFree_d = doubleFree_q | badFree;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freeMask_q   <= RESET_MASK;
            freeCount_q  <= CNT_W'(PHYS_REGS - 2 - ARCH_INIT);
            doubleFree_q <= 1'b0;
        end else begin
            freeMask_q   <= freeMask_d;
            freeCount_q  <= freeCount_d;
            doubleFree_q <= doubleFree_d;
        end
    end

    assign flBus_io.alloc_ready = allocReady;
    assign flBus_io.alloc_regs  = allocRegs;
    assign flBus_io.free_count  = freeCount_q;
    assign flBus_io.empty       = (freeCount_q == '0);
    assign flBus_io.double_free = doubleFree_q;

    // The running count must always agree with the mask it shadows.
    assert property (@(posedge clk) disable iff (rst)
        freeCount_q == CNT_W'($countones(freeMask_q)));
    assert property (@(posedge clk) disable iff (rst)
        freeMask_q[1:0] == 2'b00);
    assert property (@(posedge clk) disable iff (rst)
        freeCount_q <= CNT_W'(PHYS_REGS - 2));
endmodule

// File: tb/tb_phys_reg_freelist.sv
// Directed bench for phys_reg_freelist: stimulus pushes hand-computed expectations
// into a scoreboard queue that a negedge monitor pops and compares.
module tb_phys_reg_freelist;
    localparam int PHYS_REGS   = 64;
    localparam int PR_ADDR_W   = 6;
    localparam int ALLOC_WIDTH = 4;
    localparam int FREE_WIDTH  = 6;
    localparam int ARCH_INIT   = 8;

    typedef int freeVec_t [FREE_WIDTH];
    typedef int regVec_t [ALLOC_WIDTH];

    typedef struct {
        string                            name;
        logic [ALLOC_WIDTH*PR_ADDR_W-1:0] regs;
        logic                             rdy;
        logic [6:0]                       cnt;
        logic                             df;
    } expItem_t;

    logic     clk;
    logic     rst;
    int       checks   = 0;
    int       failures = 0;
    expItem_t expQ[$];
    freeVec_t noFree;

    phys_reg_freelist_if #(
        .PHYS_REGS(PHYS_REGS), .PR_ADDR_W(PR_ADDR_W),
        .ALLOC_WIDTH(ALLOC_WIDTH), .FREE_WIDTH(FREE_WIDTH)
    ) bus ();

    phys_reg_freelist #(
        .PHYS_REGS(PHYS_REGS), .PR_ADDR_W(PR_ADDR_W), .ALLOC_WIDTH(ALLOC_WIDTH),
        .FREE_WIDTH(FREE_WIDTH), .ARCH_INIT(ARCH_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flBus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, actual, required);
        end
    endtask

    // Drives one cycle of inputs just after the edge and queues what that cycle must show.
    task automatic applyStimulus(input string name, input bit doRst, input bit vld, input int cnt,
                                 input freeVec_t fr, input regVec_t er,
                                 input bit eRdy, input int eCnt, input bit eDf);
        expItem_t e;
        @(posedge clk);
        #1;
        rst             = doRst;
        bus.alloc_valid = vld;
        bus.alloc_count = 3'(cnt);
        for (int j = 0; j < FREE_WIDTH; j++) begin
            bus.free_regs[j*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'(fr[j]);
        end
        e.name = name;
        e.rdy  = eRdy;
        e.cnt  = 7'(eCnt);
        e.df   = eDf;
        e.regs = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            e.regs[i*PR_ADDR_W +: PR_ADDR_W] = PR_ADDR_W'(er[i]);
        end
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        expItem_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "alloc_ready", 64'(bus.alloc_ready), 64'(e.rdy));
            checkOutput(e.name, "alloc_regs",  64'(bus.alloc_regs),  64'(e.regs));
            checkOutput(e.name, "free_count",  64'(bus.free_count),  64'(e.cnt));
            checkOutput(e.name, "empty",       64'(bus.empty),       64'(e.cnt == 7'd0));
            checkOutput(e.name, "double_free", 64'(bus.double_free), 64'(e.df));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        noFree          = '{default: 0};
        rst             = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_count = '0;
        bus.free_regs   = '0;
        repeat (2) @(posedge clk);

        applyStimulus("grant4",         0, 1, 4, noFree,              '{10, 11, 12, 13}, 1, 54, 0);
        applyStimulus("after_grant4",   0, 0, 0, noFree,              '{0, 0, 0, 0},     1, 50, 0);
        applyStimulus("free11_alloc1",  0, 1, 1, '{11, 0, 0, 0, 0, 0}, '{14, 0, 0, 0},   1, 50, 0);
        applyStimulus("realloc11",      0, 1, 1, noFree,              '{11, 0, 0, 0},    1, 50, 0);
        applyStimulus("free_slots_0_1", 0, 0, 0, '{0, 1, 1, 0, 0, 1}, '{0, 0, 0, 0},     1, 49, 0);
        applyStimulus("peek4",          0, 0, 4, noFree,              '{15, 16, 17, 18}, 1, 49, 0);
        applyStimulus("illegal_count5", 0, 1, 5, noFree,              '{15, 16, 17, 18}, 0, 49, 0);
        applyStimulus("dup_slot6",      0, 0, 0, '{6, 6, 0, 0, 0, 0}, '{0, 0, 0, 0},     1, 49, 0);
        applyStimulus("after_dup6",     0, 0, 1, noFree,              '{6, 0, 0, 0},     1, 50, 1);
        applyStimulus("rst_in_grant",   1, 1, 4, noFree,              '{6, 15, 16, 17},  1, 50, 1);
        applyStimulus("post_reset",     0, 0, 4, noFree,              '{10, 11, 12, 13}, 1, 54, 0);
        applyStimulus("refree30_free5", 0, 0, 0, '{5, 30, 0, 0, 0, 0}, '{0, 0, 0, 0},    1, 54, 0);
        applyStimulus("after_refree",   0, 0, 2, noFree,              '{5, 10, 0, 0},    1, 55, 1);
        applyStimulus("plain_reset",    1, 0, 0, noFree,              '{0, 0, 0, 0},     1, 55, 1);
        applyStimulus("fresh",          0, 0, 0, noFree,              '{0, 0, 0, 0},     1, 54, 0);

        for (int k = 0; k < 13; k++) begin
            applyStimulus($sformatf("drain%0d", k), 0, 1, 4, noFree,
                          '{10 + 4*k, 11 + 4*k, 12 + 4*k, 13 + 4*k}, 1, 54 - 4*k, 0);
        end

        applyStimulus("short_req4",      0, 1, 4, noFree,              '{62, 63, 0, 0},  0, 2, 0);
        applyStimulus("req2",            0, 1, 2, noFree,              '{62, 63, 0, 0},  1, 2, 0);
        applyStimulus("empty_req1",      0, 1, 1, noFree,              '{0, 0, 0, 0},    0, 0, 0);
        applyStimulus("empty_req0",      0, 1, 0, noFree,              '{0, 0, 0, 0},    1, 0, 0);
        applyStimulus("free12",          0, 0, 0, '{12, 0, 0, 0, 0, 0}, '{0, 0, 0, 0},   1, 0, 0);
        applyStimulus("refree12_free13", 0, 0, 0, '{0, 12, 0, 13, 0, 0}, '{0, 0, 0, 0},  1, 1, 0);
        applyStimulus("grant12_free12",  0, 1, 1, '{0, 0, 0, 0, 0, 12}, '{12, 0, 0, 0}, 1, 2, 1);
        applyStimulus("after_bad_free",  0, 0, 2, noFree,              '{13, 0, 0, 0},   0, 1, 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard", "pending", 64'(expQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
